// File: rtl/ro_race_counter_if.sv
// Signal bundle between an RO pair and the race counter: start request, raw RO inputs and race results.
interface ro_race_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             cout1;
  logic             cout2;
  logic [WIDTH-1:0] count1;
  logic [WIDTH-1:0] count2;
  logic             busy;
  logic             done;
  logic             resp;
  logic             tie;
  logic             timeout;

  modport master (
    output start, cout1, cout2,
    input  count1, count2, busy, done, resp, tie, timeout
  );

  modport slave (
    input  start, cout1, cout2,
    output count1, count2, busy, done, resp, tie, timeout
  );
endinterface

// File: rtl/ro_race_counter.sv
// RO-PUF race counter: counts synchronised rising edges of two ring oscillators and reports the first to reach LIMIT.
// Optional cycle-budget timeout enabled by defining ROPUF_TIMEOUT_EN.
module ro_race_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LIMIT       = 2**WIDTH - 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic             clk,
  input logic             reset_n,
  ro_race_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync2_q;
  logic                   hist1_q, hist2_q;
  logic                   inc1, inc2;
  logic [WIDTH-1:0]       count1_q, count1_d, count2_q, count2_d;
  logic [WIDTH-1:0]       nxt1, nxt2;
  logic                   hit1, hit2;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   resp_q, resp_d, tie_q, tie_d;

`ifdef ROPUF_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_CYC = CW'(TIMEOUT_CYC);
  logic [CW-1:0] cyc_q, cyc_d;
  logic          timeout_q, timeout_d;
`endif

  // Synchronisers plus history flop; history keeps tracking outside RUN so no false edge at START
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], bus.cout1};
      sync2_q <= {sync2_q[SYNC_STAGES-2:0], bus.cout2};
      hist1_q <= sync1_q[SYNC_STAGES-1];
      hist2_q <= sync2_q[SYNC_STAGES-1];
    end
  end

  assign inc1 = sync1_q[SYNC_STAGES-1] & ~hist1_q;
  assign inc2 = sync2_q[SYNC_STAGES-1] & ~hist2_q;

  // Next-state and next-result logic
  always_comb begin
    state_d  = state_q;
    count1_d = count1_q;
    count2_d = count2_q;
    busy_d   = busy_q;
    done_d   = done_q;
    resp_d   = resp_q;
    tie_d    = tie_q;
    nxt1     = count1_q + WIDTH'(inc1);
    nxt2     = count2_q + WIDTH'(inc2);
    hit1     = (nxt1 == LIM);
    hit2     = (nxt2 == LIM);
`ifdef ROPUF_TIMEOUT_EN
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          count1_d = '0;
          count2_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          resp_d   = 1'b0;
          tie_d    = 1'b0;
`ifdef ROPUF_TIMEOUT_EN
          cyc_d     = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if ((count1_q != LIM) && (count2_q != LIM)) begin
          count1_d = nxt1;
          count2_d = nxt2;
        end
`ifdef ROPUF_TIMEOUT_EN
        cyc_d = cyc_q + CW'(1);
`endif
        if (hit1 || hit2) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          resp_d  = hit1 & ~hit2;
          tie_d   = hit1 & hit2;
        end
`ifdef ROPUF_TIMEOUT_EN
        else if (cyc_q + CW'(1) == TO_CYC) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          resp_d    = (nxt1 > nxt2);
          tie_d     = (nxt1 == nxt2);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count1_q <= '0;
      count2_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count1_q <= count1_d;
      count2_q <= count2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
      tie_q    <= tie_d;
    end
  end

`ifdef ROPUF_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.count1 = count1_q;
  assign bus.count2 = count2_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.resp   = resp_q;
  assign bus.tie    = tie_q;

endmodule

// File: tb/tb_ro_race_counter.sv
// Directed bench for ro_race_counter: races with known RO periods, tie, async reset, START handling, timeout budget.
module tb_ro_race_counter;
  localparam int unsigned WIDTH = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic en1     = 1'b0;
  logic en2     = 1'b0;
  logic ro_same = 1'b0;
  logic ro1     = 1'b0;
  logic ro2     = 1'b0;
  int   hp1     = 50;
  int   hp2     = 70;
  int   checks  = 0;
  int   errors  = 0;
  int   n;

  ro_race_counter_if #(.WIDTH(WIDTH)) bus ();

  ro_race_counter #(
    .WIDTH      (WIDTH),
    .LIMIT      (15),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(1000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  assign bus.cout1 = ro1;
  assign bus.cout2 = ro_same ? ro1 : ro2;

  always #5 clk = ~clk;

  // Free-running oscillators; half periods are multiples of 10 ns so toggles never hit a rising clk edge
  initial forever begin
    #(hp1);
    ro1 = en1 ? ~ro1 : 1'b0;
  end

  initial forever begin
    #(hp2);
    ro2 = en2 ? ~ro2 : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < maxc) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_reached", 32'(bus.done), 32'd1);
  endtask

  task automatic chk_started(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_count1"}, 32'(bus.count1), 32'd0);
    chk({tag, "_count2"}, 32'(bus.count2), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count1", 32'(bus.count1), 32'd0);
    chk("rst_count2", 32'(bus.count2), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_resp", 32'(bus.resp), 32'd0);
    chk("rst_tie", 32'(bus.tie), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    reset_n = 1'b1;

    // RO1 faster
    hp1 = 50; hp2 = 70; en1 = 1'b1; en2 = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start();
    chk_started("r1_start");
    wait_done(400, n);
    chk("r1_count1", 32'(bus.count1), 32'd15);
    chk("r1_count2_range", 32'(bus.count2 >= 4'd10 && bus.count2 <= 4'd11), 32'd1);
    chk("r1_resp", 32'(bus.resp), 32'd1);
    chk("r1_tie", 32'(bus.tie), 32'd0);
    chk("r1_busy", 32'(bus.busy), 32'd0);

    // RO2 faster, restarted straight from DONE
    hp1 = 70; hp2 = 50;
    repeat (4) @(negedge clk);
    pulse_start();
    chk_started("r2_start");
    wait_done(400, n);
    chk("r2_count2", 32'(bus.count2), 32'd15);
    chk("r2_count1_range", 32'(bus.count1 >= 4'd10 && bus.count1 <= 4'd11), 32'd1);
    chk("r2_resp", 32'(bus.resp), 32'd0);
    chk("r2_tie", 32'(bus.tie), 32'd0);

    // Both inputs from one source
    hp1 = 50; ro_same = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start();
    wait_done(400, n);
    chk("tie_count1", 32'(bus.count1), 32'd15);
    chk("tie_count2", 32'(bus.count2), 32'd15);
    chk("tie_tie", 32'(bus.tie), 32'd1);
    chk("tie_resp", 32'(bus.resp), 32'd0);
    ro_same = 1'b0; hp2 = 70;

    // Async reset mid-race at COUNT1=7
    repeat (4) @(negedge clk);
    pulse_start();
    n = 0;
    while (bus.count1 !== 4'd7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached7", 32'(bus.count1), 32'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count1", 32'(bus.count1), 32'd0);
    chk("mid_rst_count2", 32'(bus.count2), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_done", 32'(bus.done), 32'd0);
    pulse_start();
    chk_started("fresh_start");
    wait_done(400, n);
    chk("fresh_count1", 32'(bus.count1), 32'd15);
    chk("fresh_resp", 32'(bus.resp), 32'd1);

    // START asserted in DONE and held through the whole race
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk);
    chk_started("held_start");
    wait_done(400, n);
    bus.start = 1'b0;
    chk("held_count1", 32'(bus.count1), 32'd15);
    chk("held_count2_range", 32'(bus.count2 >= 4'd10 && bus.count2 <= 4'd11), 32'd1);
    chk("held_resp", 32'(bus.resp), 32'd1);
    chk("held_tie", 32'(bus.tie), 32'd0);

    // Silent oscillators: only the cycle budget can end the race
    en1 = 1'b0; en2 = 1'b0;
    repeat (20) @(negedge clk);
    pulse_start();
    chk_started("idle_ro_start");
`ifdef ROPUF_TIMEOUT_EN
    wait_done(1100, n);
    chk("to_cycles", 32'(n), 32'd1000);
    chk("to_timeout", 32'(bus.timeout), 32'd1);
    chk("to_tie", 32'(bus.tie), 32'd1);
    chk("to_resp", 32'(bus.resp), 32'd0);
    chk("to_busy", 32'(bus.busy), 32'd0);
`else
    repeat (1100) @(negedge clk);
    chk("noto_busy", 32'(bus.busy), 32'd1);
    chk("noto_done", 32'(bus.done), 32'd0);
    chk("noto_timeout", 32'(bus.timeout), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
